// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared constants and types for the delivery arbiter slice.
// No ports. It provides the buffer, cell and length sizes, the address and
// priority-pointer types, the arbiter state enum and a wrap-around index
// helper for the rotating priority scan.
// ---------------------------------------------------------------------------
package router_pkg;

    localparam int NUM_BUF   = 7;
    localparam int ADDR_W    = 4;
    localparam int NUM_CELLS = 2 ** ADDR_W;
    localparam int LEN_W     = 6;
    localparam int PTR_W     = $clog2(NUM_BUF);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [PTR_W-1:0]  ptr_t;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        XFER,
        DONE
    } arb_state_t;

    // (base + off) mod NUM_BUF. Both operands are already below NUM_BUF, so
    // one conditional subtract is enough.
    function automatic ptr_t wrap_idx(ptr_t base, ptr_t off);
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (PTR_W+1)'(NUM_BUF)) begin
            sum = sum - (PTR_W+1)'(NUM_BUF);
        end
        return sum[PTR_W-1:0];
    endfunction

endpackage

// File: rtl/delivery_arbiter_if.sv
// ---------------------------------------------------------------------------
// delivery_arbiter_if
// Bundles the request and grant signals between the buffer identifier logic
// (master) and the delivery arbiter (slave).
//   start     : pulse that begins a delivery cycle
//   msg_len   : bits per message
//   req       : per-buffer request
//   addr_flat : buffer i destination at [i*ADDR_W +: ADDR_W]
//   sel       : per-buffer select / shift-out strobe
//   busy      : arbiter not idle
//   done      : one-cycle end-of-cycle pulse
//   rejected  : requesters that lost in the last cycle
//   cell_map  : cells claimed by the current grant set
// ---------------------------------------------------------------------------
interface delivery_arbiter_if;
    import router_pkg::*;

    logic                      start;
    logic [LEN_W-1:0]          msg_len;
    logic [NUM_BUF-1:0]        req;
    logic [NUM_BUF*ADDR_W-1:0] addr_flat;
    logic [NUM_BUF-1:0]        sel;
    logic                      busy;
    logic                      done;
    logic [NUM_BUF-1:0]        rejected;
    logic [NUM_CELLS-1:0]      cell_map;

    modport master (
        output start, msg_len, req, addr_flat,
        input  sel, busy, done, rejected, cell_map
    );

    modport slave (
        input  start, msg_len, req, addr_flat,
        output sel, busy, done, rejected, cell_map
    );

endinterface

// File: rtl/conflict_resolver.sv
// ---------------------------------------------------------------------------
// conflict_resolver
// Purely combinational. It scans the buffers starting at prio_ptr and
// wraps mod NUM_BUF. A requesting buffer is granted if no buffer scanned
// before it has claimed the same cell address.
//   req_q    : latched requests
//   addr_q   : latched destination addresses
//   prio_ptr : first buffer in the scan
//   grant    : granted buffers (at most one per cell)
//   cell_map : one-hot OR of the granted addresses
// ---------------------------------------------------------------------------
module conflict_resolver
    import router_pkg::*;
(
    input  logic [NUM_BUF-1:0]   req_q,
    input  addr_t [NUM_BUF-1:0]  addr_q,
    input  ptr_t                 prio_ptr,
    output logic [NUM_BUF-1:0]   grant,
    output logic [NUM_CELLS-1:0] cell_map
);

    // cell_map also serves as the running "claimed" set during the scan.
    always_comb begin
        grant    = '0;
        cell_map = '0;
        for (int k = 0; k < NUM_BUF; k++) begin
            if (req_q[wrap_idx(prio_ptr, ptr_t'(k))] &&
                !cell_map[addr_q[wrap_idx(prio_ptr, ptr_t'(k))]]) begin
                grant[wrap_idx(prio_ptr, ptr_t'(k))]             = 1'b1;
                cell_map[addr_q[wrap_idx(prio_ptr, ptr_t'(k))]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/delivery_arbiter.sv
// ---------------------------------------------------------------------------
// delivery_arbiter
// Sequences one bit-serial delivery cycle: latch requests, resolve address
// conflicts, hold sel for msg_len bit times, then pulse done and report the
// losers in rejected.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : delivery_arbiter_if.slave (start/msg_len/req/addr_flat in;
//           sel/busy/done/rejected/cell_map out)
// Optional feature: define DELIVERY_ARB_ROTATE_EN for round-robin priority.
// The pointer then advances once per delivery cycle. When the macro is
// undefined, priority is fixed and buffer 0 is highest.
// ---------------------------------------------------------------------------
module delivery_arbiter
    import router_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    delivery_arbiter_if.slave bus
);

    arb_state_t           state;
    arb_state_t           state_next;
    logic [NUM_BUF-1:0]   req_q;
    addr_t [NUM_BUF-1:0]  addr_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     bit_cnt;
    logic [NUM_BUF-1:0]   grant_q;
    logic [NUM_BUF-1:0]   rejected_q;
    logic [NUM_CELLS-1:0] cell_map_q;
    ptr_t                 prio_ptr;
    logic [NUM_BUF-1:0]   grant_c;
    logic [NUM_CELLS-1:0] cell_map_c;
    logic                 accept;
    logic                 last_bit;

    // A zero-length start is dropped entirely, so it never leaves IDLE.
    assign accept   = (state == IDLE) && bus.start && (bus.msg_len != '0);
    assign last_bit = (bit_cnt == len_q - LEN_W'(1));

    conflict_resolver u_resolver (
        .req_q    (req_q),
        .addr_q   (addr_q),
        .prio_ptr (prio_ptr),
        .grant    (grant_c),
        .cell_map (cell_map_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. sel, busy and done decode directly from the state,
    // so a reset drops all of them on the very next edge.
    always_comb begin
        state_next = state;
        bus.sel    = '0;
        bus.busy   = 1'b1;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (accept) begin
                    state_next = ARB;
                end
            end
            ARB: begin
                state_next = XFER;
            end
            XFER: begin
                bus.sel = grant_q;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers. Inputs are captured only on an accepted start.
    // rejected is loaded on the last bit so it is already valid during DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            bit_cnt    <= '0;
            grant_q    <= '0;
            rejected_q <= '0;
            cell_map_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_q      <= bus.req;
                        addr_q     <= bus.addr_flat;
                        len_q      <= bus.msg_len;
                        rejected_q <= '0;
                    end
                end
                ARB: begin
                    grant_q    <= grant_c;
                    cell_map_q <= cell_map_c;
                    bit_cnt    <= '0;
                end
                XFER: begin
                    bit_cnt <= bit_cnt + LEN_W'(1);
                    if (last_bit) begin
                        rejected_q <= req_q & ~grant_q;
                    end
                end
                DONE: begin
                    cell_map_q <= '0;
                end
                default: begin
                    cell_map_q <= '0;
                end
            endcase
        end
    end

`ifdef DELIVERY_ARB_ROTATE_EN
    // The round-robin pointer moves one buffer per completed delivery cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_ptr <= '0;
        end else if (state == DONE) begin
            prio_ptr <= wrap_idx(prio_ptr, ptr_t'(1));
        end
    end
`else
    assign prio_ptr = '0;
`endif

    assign bus.rejected = rejected_q;
    assign bus.cell_map = cell_map_q;

endmodule

// File: doc/delivery_arbiter.md
Name: delivery_arbiter

Overview:
- Sequences one bit-serial delivery cycle for the 7-buffer to 16-cell distributor datapath.
- Latches buffer requests and 4-bit destination addresses, then resolves address conflicts so that at most one buffer drives each cell.
- Holds the resulting select flags for exactly msg_len bit times, then reports losers for retry.
- Sits between the buffer identifier logic and the distributor's sel inputs.

Parameters:
- NUM_BUF, 7, number of message buffers (requesters).
- ADDR_W, 4, destination cell address width.
- NUM_CELLS, 16, number of destination cells; equals 2**ADDR_W.
- LEN_W, 6, width of the message-length and bit counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse; begin a delivery cycle (honoured only in IDLE)
- msg_len  in  LEN_W  bits per message, sampled on accepted start
- req  in  NUM_BUF  per-buffer request, sampled on accepted start
- addr_flat  in  NUM_BUF*ADDR_W  buffer i address at bits [i*ADDR_W +: ADDR_W], sampled on accepted start
- sel  out  NUM_BUF  per-buffer select to distributor; also the buffer's shift-out strobe
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of cycle
- rejected  out  NUM_BUF  requesters not granted in last cycle; held until next accepted start
- cell_map  out  NUM_CELLS  cells claimed by the current grant set

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-low, on rst_n.
  - Reset values: state=IDLE, sel=0, busy=0, done=0, rejected=0, cell_map=0, prio_ptr=0, bit_cnt=0.
  - Reset asserted mid-cycle aborts immediately. sel drops on the next edge and no done is produced.
- FSM states: IDLE, ARB, XFER, DONE.
- IDLE:
  - A start with msg_len!=0 latches req_q, addr_q, len_q, clears rejected, and moves to ARB.
  - A start with msg_len==0 is ignored; state stays IDLE.
- ARB (1 cycle):
  - Scan buffers in priority order beginning at prio_ptr, wrapping mod NUM_BUF.
  - Grant buffer i if req_q[i]=1 and addr_q[i] is not already claimed by an earlier-scanned grant.
  - Register grant and cell_map (OR of one-hot(addr) over grants). Set bit_cnt=0 and move to XFER.
  - If req_q==0, grant=0 and the FSM still passes through XFER for len_q cycles, which keeps timing fixed.
- XFER:
  - sel=grant for exactly len_q consecutive cycles; bit_cnt increments each cycle.
  - When bit_cnt==len_q-1, move to DONE.
- DONE (1 cycle):
  - sel=0, done=1, rejected=req_q & ~grant.
  - prio_ptr advances to (prio_ptr+1) mod NUM_BUF. Move to IDLE.
  - cell_map clears on entering IDLE.
- Latency:
  - start to first sel cycle: 2 clocks.
  - start to done: len_q+2 clocks.
  - back-to-back start is accepted the cycle after done.
- start while busy is ignored and has no effect on latched values.
- Invariant: for any two granted buffers i!=j, addr_q[i]!=addr_q[j]. sel never has a bit set outside req_q.

Optional Feature:
- Macro DELIVERY_ARB_ROTATE_EN.
- Defined: round-robin behaviour as above; prio_ptr rotates every cycle.
- Undefined: fixed priority, buffer 0 highest; prio_ptr is tied to 0 and not advanced.

Decomposition:
- Shared package router_pkg: NUM_BUF, ADDR_W, NUM_CELLS, LEN_W constants; arb_state_t enum {IDLE, ARB, XFER, DONE}; addr_t typedef.
- Sub-module conflict_resolver: purely combinational. Inputs req_q, addr_q, prio_ptr; outputs grant and cell_map. It is instantiated once, and its outputs are registered in ARB.

Test Plan:
- Reset, then start, msg_len=5, req=7'b0000111, addrs 3,9,12 -> sel=0000111 for exactly 5 cycles starting 2 clocks after start; done 7 clocks after start; rejected=0.
- Conflict: req=7'b0000011, both addr=4, prio_ptr=0 -> grant=0000001, rejected=0000010, cell_map=16'h0010. Repeat the cycle -> with ROTATE_EN grant=0000010; without, grant=0000001.
- All 7 requesting address 0 in rotate mode, 7 consecutive cycles -> each buffer granted exactly once, in order 0..6.
- start with msg_len=0 -> busy stays 0 and no done. A start pulse during XFER -> ignored, sel unchanged, done on the original schedule.
- rst_n low in the 3rd XFER cycle of msg_len=10 -> sel=0, busy=0 next edge, no done. The next start behaves as in a fresh reset.
- msg_len=63 (max) with req=0 -> sel stays 0, busy for 65 cycles, done pulses, rejected=0.
